fft_frame_feeder: RTL and testbench



---
 rtl/fft_frame_feeder.sv | 206 ++++++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_feeder.sv
// Per-channel feeder between the windowing stage and the FFT core: buffers samples in a
// FWFT FIFO, places tlast, zero-pads short frames and sends the FFT config word after reset.
module fft_frame_feeder #(
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter logic [15:0] CONFIG_WORD = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        data_in_en,
  input  logic        stream_last_in,
  output logic [15:0] s_axis_config_tdata,
  output logic        s_axis_config_tvalid,
  input  logic        s_axis_config_tready,
  output logic [63:0] m_axis_data_tdata,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready,
  output logic        m_axis_data_tlast,
  output logic        frame_err,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FRAME_LEN);

  typedef enum logic {CFG_SEND = 1'b0, CFG_DONE = 1'b1} cfg_state_t;
  typedef enum logic {IN_IDLE = 1'b0, IN_PAD = 1'b1} in_state_t;

  cfg_state_t    r_cfg_state;
  cfg_state_t    w_cfg_state_nxt;
  logic          r_cfg_tvalid;
  logic          w_cfg_tvalid_nxt;

  in_state_t     r_in_state;
  in_state_t     w_in_state_nxt;
  logic [CW-1:0] r_in_cnt;
  logic [CW-1:0] w_in_cnt_nxt;
  logic [CW-1:0] w_in_cnt_inc;
  logic          w_wr_en;
  logic [31:0]   w_wr_data;
  logic          w_drop;
  logic          w_frame_err_nxt;
  logic          r_frame_err;
  logic          r_overflow;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   w_rd_ptr_nxt;
  logic          w_full;
  logic          w_can_write;
  logic [31:0]   r_out_data;
  logic          r_out_valid;

  logic [CW-1:0] r_out_cnt;
  logic [15:0]   r_frame_cnt;
  logic          w_cfg_done;
  logic          w_tvalid;
  logic          w_tlast;
  logic          w_rd_en;

  assign w_cfg_done   = (r_cfg_state == CFG_DONE);
  assign w_tvalid     = r_out_valid && w_cfg_done;
  assign w_tlast      = w_tvalid && (r_out_cnt == CW'(FRAME_LEN - 1));
  assign w_rd_en      = w_tvalid && m_axis_data_tready;
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_rd_en};
  // Pointers carry an extra wrap bit: equal index with differing wrap bits means full.
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_can_write  = !w_full || w_rd_en;
  assign w_in_cnt_inc = r_in_cnt + {{(CW-1){1'b0}}, 1'b1};

  assign s_axis_config_tvalid = r_cfg_tvalid;
  assign s_axis_config_tdata  = r_cfg_tvalid ? CONFIG_WORD : 16'h0000;
  assign m_axis_data_tdata    = {32'h0000_0000, r_out_data};
  assign m_axis_data_tvalid   = w_tvalid;
  assign m_axis_data_tlast    = w_tlast;
  assign frame_err            = r_frame_err;
  assign overflow             = r_overflow;
  assign frame_cnt            = r_frame_cnt;

  // Config FSM next state; tvalid is registered so it reads 0 while in reset.
  always_comb begin
    w_cfg_state_nxt  = r_cfg_state;
    w_cfg_tvalid_nxt = 1'b0;
    case (r_cfg_state)
      CFG_SEND: begin
        if (r_cfg_tvalid && s_axis_config_tready) begin
          w_cfg_state_nxt  = CFG_DONE;
          w_cfg_tvalid_nxt = 1'b0;
        end else begin
          w_cfg_tvalid_nxt = 1'b1;
        end
      end
      CFG_DONE: w_cfg_tvalid_nxt = 1'b0;
      default:  w_cfg_state_nxt  = CFG_SEND;
    endcase
  end

  // Config FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_state  <= CFG_SEND;
      r_cfg_tvalid <= 1'b0;
    end else begin
      r_cfg_state  <= w_cfg_state_nxt;
      r_cfg_tvalid <= w_cfg_tvalid_nxt;
    end
  end

  // Input FSM: frame-end is judged on the count after any same-cycle write.
  always_comb begin
    w_in_state_nxt  = r_in_state;
    w_in_cnt_nxt    = r_in_cnt;
    w_wr_en         = 1'b0;
    w_wr_data       = 32'h0000_0000;
    w_drop          = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_in_state)
      IN_IDLE: begin
        if (data_in_en) begin
          if (w_can_write) begin
            w_wr_en      = 1'b1;
            w_wr_data    = data_in;
            w_in_cnt_nxt = w_in_cnt_inc;
          end else begin
            w_drop = 1'b1;
          end
        end else begin
          w_drop = 1'b0;
        end
        if (stream_last_in && (w_in_cnt_nxt != {CW{1'b0}})) begin
          w_in_state_nxt  = IN_PAD;
          w_frame_err_nxt = 1'b1;
        end else begin
          w_in_state_nxt = IN_IDLE;
        end
      end
      IN_PAD: begin
        w_drop = data_in_en;
        if (w_can_write) begin
          w_wr_en        = 1'b1;
          w_in_cnt_nxt   = w_in_cnt_inc;
          w_in_state_nxt = (r_in_cnt == CW'(FRAME_LEN - 1)) ? IN_IDLE : IN_PAD;
        end else begin
          w_in_state_nxt = IN_PAD;
        end
      end
      default: w_in_state_nxt = IN_IDLE;
    endcase
  end

  // Input FSM registers and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_state  <= IN_IDLE;
      r_in_cnt    <= {CW{1'b0}};
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_in_state  <= w_in_state_nxt;
      r_in_cnt    <= w_in_cnt_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overflow  <= r_overflow | w_drop;
    end
  end

  // Sample storage; contents are don't-care until the write pointer covers them.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
    end
  end

  // Output stage mirrors the head entry, so a held beat stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= {(AW+1){1'b0}};
      r_rd_ptr    <= {(AW+1){1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0000_0000;
    end else begin
      r_wr_ptr    <= r_wr_ptr + {{AW{1'b0}}, w_wr_en};
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_out_valid <= (r_wr_ptr != w_rd_ptr_nxt);
      r_out_data  <= r_mem[w_rd_ptr_nxt[AW-1:0]];
    end
  end

  // Beat position within the frame and delivered-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt   <= {CW{1'b0}};
      r_frame_cnt <= 16'h0000;
    end else if (w_rd_en) begin
      r_out_cnt   <= r_out_cnt + {{(CW-1){1'b0}}, 1'b1};
      r_frame_cnt <= r_frame_cnt + {15'h0000, w_tlast};
    end else begin
      r_out_cnt   <= r_out_cnt;
      r_frame_cnt <= r_frame_cnt;
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Randomized bench for fft_frame_feeder: a queue-based reference model predicts the beat
// stream, padding, tlast placement, frame errors, overflow and frame count.
module tb_fft_frame_feeder;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        data_in_en;
  logic        stream_last_in;
  logic [15:0] s_axis_config_tdata;
  logic        s_axis_config_tvalid;
  logic        s_axis_config_tready;
  logic [63:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready;
  logic        m_axis_data_tlast;
  logic        frame_err;
  logic        overflow;
  logic [15:0] frame_cnt;

  fft_frame_feeder dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .data_in              (data_in),
    .data_in_en           (data_in_en),
    .stream_last_in       (stream_last_in),
    .s_axis_config_tdata  (s_axis_config_tdata),
    .s_axis_config_tvalid (s_axis_config_tvalid),
    .s_axis_config_tready (s_axis_config_tready),
    .m_axis_data_tdata    (m_axis_data_tdata),
    .m_axis_data_tvalid   (m_axis_data_tvalid),
    .m_axis_data_tready   (m_axis_data_tready),
    .m_axis_data_tlast    (m_axis_data_tlast),
    .frame_err            (frame_err),
    .overflow             (overflow),
    .frame_cnt            (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] q[$];
  int          m_in;
  int          beat_pos;
  bit          m_pad;
  bit          m_ovf;
  bit          exp_err;
  logic [15:0] m_frames;
  bit          stall_prev;
  logic [63:0] prev_tdata;
  logic        prev_tlast;

  int cyc = 0;
  int rmode = 0;
  int n_beats = 0;
  int n_tlast = 0;
  int n_errp = 0;
  bit lat_arm = 1'b0;
  int lat_first = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fp32(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0000_0000;
    e = 0;
    for (int b = 0; b < 31; b++) if (((v >> b) & 1) == 1) e = b;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic model_reset();
    q.delete();
    m_in = 0; beat_pos = 0; m_pad = 1'b0; m_ovf = 1'b0; exp_err = 1'b0;
    m_frames = 16'h0000; stall_prev = 1'b0;
  endtask

  // One clock cycle: inputs are already driven; compare, advance the model, step to next negedge.
  task automatic cycle();
    bit xfer;
    bit can;
    bit err_next;
    int sz;
    logic [31:0] e;
    case (rmode)
      0: m_axis_data_tready = 1'b1;
      1: m_axis_data_tready = ((cyc % 3) == 0);
      2: m_axis_data_tready = 1'($urandom_range(0, 1));
      default: m_axis_data_tready = 1'b0;
    endcase
    check_eq("frame_err", 64'(frame_err), 64'(exp_err));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("frame_cnt", 64'(frame_cnt), 64'(m_frames));
    check_eq("tlast", 64'(m_axis_data_tlast), 64'(m_axis_data_tvalid && (beat_pos == 255)));
    if (stall_prev) begin
      check_eq("stall_tvalid", 64'(m_axis_data_tvalid), 64'd1);
      check_eq("stall_tdata", m_axis_data_tdata, prev_tdata);
      check_eq("stall_tlast", 64'(m_axis_data_tlast), 64'(prev_tlast));
    end
    if (frame_err) n_errp++;
    if (lat_arm && m_axis_data_tvalid) begin
      lat_first = cyc;
      lat_arm = 1'b0;
    end
    xfer = m_axis_data_tvalid && m_axis_data_tready;
    sz = q.size();
    if (xfer) begin
      check_eq("beat_available", 64'(sz != 0), 64'd1);
      if (sz != 0) begin
        e = q.pop_front();
        check_eq("tdata", m_axis_data_tdata, {32'h0, e});
        if (beat_pos == 255) begin
          m_frames = m_frames + 16'd1;
          n_tlast++;
        end
        beat_pos = (beat_pos + 1) % 256;
        n_beats++;
      end
    end
    can = (sz < 512) || xfer;
    err_next = 1'b0;
    if (!m_pad) begin
      if (data_in_en) begin
        if (can) begin q.push_back(data_in); m_in = (m_in + 1) % 256; end
        else m_ovf = 1'b1;
      end
      if (stream_last_in && (m_in != 0)) begin m_pad = 1'b1; err_next = 1'b1; end
    end else begin
      if (data_in_en) m_ovf = 1'b1;
      if (can) begin
        q.push_back(32'h0);
        m_in = (m_in + 1) % 256;
        if (m_in == 0) m_pad = 1'b0;
      end
    end
    exp_err = err_next;
    stall_prev = m_axis_data_tvalid && !m_axis_data_tready;
    prev_tdata = m_axis_data_tdata;
    prev_tlast = m_axis_data_tlast;
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_cfg_tvalid", 64'(s_axis_config_tvalid), 64'd0);
    check_eq("rst_cfg_tdata", 64'(s_axis_config_tdata), 64'd0);
    check_eq("rst_tvalid", 64'(m_axis_data_tvalid), 64'd0);
    check_eq("rst_tdata", m_axis_data_tdata, 64'd0);
    check_eq("rst_tlast", 64'(m_axis_data_tlast), 64'd0);
    check_eq("rst_frame_err", 64'(frame_err), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
  endtask

  task automatic do_config(input int hold);
    int hi;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      s_axis_config_tready = (hi >= hold);
      if (s_axis_config_tvalid) begin
        hi++;
        check_eq("cfg_tdata", 64'(s_axis_config_tdata), 64'h0001);
        check_eq("cfg_data_tvalid_low", 64'(m_axis_data_tvalid), 64'd0);
      end
      cycle();
    end
    check_eq("cfg_high_cycles", 64'(hi), 64'(hold + 1));
  endtask

  // lag < 0: frame-end marker shares the cycle of the last sample.
  task automatic send(input int n, input int lag, input bit nominal, input bit gaps);
    int g;
    for (int i = 0; i < n; i++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      data_in_en = 1'b0; stream_last_in = 1'b0;
      repeat (g) cycle();
      data_in_en = 1'b1;
      data_in = nominal ? fp32(i) : $urandom;
      stream_last_in = (lag < 0) && (i == n - 1);
      cycle();
    end
    data_in_en = 1'b0; stream_last_in = 1'b0;
    if (lag >= 0) begin
      repeat (lag) cycle();
      stream_last_in = 1'b1;
      cycle();
      stream_last_in = 1'b0;
    end
  endtask

  task automatic drain(input int max_cyc);
    for (int k = 0; k < max_cyc && (q.size() != 0 || m_pad || m_axis_data_tvalid); k++) cycle();
    check_eq("drain_queue_empty", 64'(q.size()), 64'd0);
    check_eq("drain_tvalid_low", 64'(m_axis_data_tvalid), 64'd0);
  endtask

  initial begin
    int b0;
    int t0;
    int e0;
    int c0;
    rst_n = 1'b0; data_in = 32'h0; data_in_en = 1'b0; stream_last_in = 1'b0;
    s_axis_config_tready = 1'b0; m_axis_data_tready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    do_config(10);

    // nominal frame, ramp of floats, first-sample latency
    rmode = 0; e0 = n_errp; b0 = n_beats;
    c0 = cyc; lat_arm = 1'b1;
    send(256, 21, 1'b1, 1'b0);
    drain(2000);
    check_eq("nom_latency", 64'(lat_first - c0), 64'd2);
    check_eq("nom_beats", 64'(n_beats - b0), 64'd256);
    check_eq("nom_frame_cnt", 64'(frame_cnt), 64'd1);
    check_eq("nom_no_frame_err", 64'(n_errp - e0), 64'd0);

    // short frame padded, then an aligned frame with marker on the last sample
    e0 = n_errp; b0 = n_beats;
    send(200, 0, 1'b0, 1'b1);
    drain(2000);
    check_eq("short_err_pulses", 64'(n_errp - e0), 64'd1);
    check_eq("short_beats", 64'(n_beats - b0), 64'd256);
    send(256, -1, 1'b0, 1'b1);
    drain(2000);
    check_eq("aligned_err_pulses", 64'(n_errp - e0), 64'd1);
    check_eq("aligned_frame_cnt", 64'(frame_cnt), 64'd3);

    // backpressure pattern 1,0,0 over two frames
    rmode = 1; b0 = n_beats;
    send(256, int'($urandom_range(0, 30)), 1'b0, 1'b1);
    send(256, int'($urandom_range(0, 30)), 1'b0, 1'b1);
    drain(3000);
    check_eq("bp_beats", 64'(n_beats - b0), 64'd512);
    check_eq("bp_frame_cnt", 64'(frame_cnt), 64'd5);

    // random ready, random-length short frame
    rmode = 2;
    send(256, int'($urandom_range(0, 5)), 1'b0, 1'b1);
    send(int'($urandom_range(1, 255)), int'($urandom_range(0, 5)), 1'b0, 1'b1);
    drain(3000);
    check_eq("rnd_frame_cnt", 64'(frame_cnt), 64'd7);

    // overflow: stalled sink, 600 samples, then release
    rmode = 3; b0 = n_beats; t0 = n_tlast;
    send(600, -2, 1'b0, 1'b0);
    check_eq("ovf_flag", 64'(overflow), 64'd1);
    check_eq("ovf_stored", 64'(q.size()), 64'd512);
    rmode = 0;
    drain(2000);
    check_eq("ovf_beats", 64'(n_beats - b0), 64'd512);
    check_eq("ovf_tlasts", 64'(n_tlast - t0), 64'd2);
    check_eq("ovf_frame_cnt", 64'(frame_cnt), 64'd9);

    // reset after 100 beats of a frame
    b0 = n_beats;
    for (int i = 0; i < 256 && (n_beats - b0) < 100; i++) begin
      data_in_en = 1'b1; data_in = $urandom; cycle();
    end
    data_in_en = 1'b0;
    check_eq("mid_beats_before_reset", 64'(n_beats - b0), 64'd100);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    repeat (2) cycle();
    rst_n = 1'b1;
    do_config(0);
    b0 = n_beats;
    send(256, 3, 1'b0, 1'b1);
    drain(2000);
    check_eq("post_rst_beats", 64'(n_beats - b0), 64'd256);
    check_eq("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
